// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Width of a requester index; never narrower than one bit so that a
  // single-requester build still has a legal grant_id port.
  function automatic int id_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first set bit of valid searching upward
// from ptr with wrap-around, plus a flag saying whether any bit was set.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  logic [W:0]   sum_s;
  logic [W-1:0] idx_s;

  // Walk the N candidates starting at ptr; the first valid one wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (W+1)'(i);
      if (sum_s >= (W+1)'(N)) begin
        sum_s = sum_s - (W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[W-1:0];
      if (!any_valid && valid[idx_s]) begin
        winner    = idx_s;
        any_valid = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one unbuffered UART transmitter among NUM_REQ byte streams.
// Round-robin arbitration with packet lock; the grantee keeps the link until
// its last-tagged byte has left the transmitter, or until it stalls too long.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_BITS    = 8,
  parameter  int STALL_CYCLES = 1000000,
  localparam int ID_W         = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_send,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_busy,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic                         stall_err
);

  localparam int              CNT_W     = $clog2(STALL_CYCLES);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e           state_r;
  logic [ID_W-1:0]      ptr_r;
  logic                 last_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [DATA_BITS-1:0] tx_data_r;

  logic [DATA_BITS-1:0] req_byte_s [NUM_REQ];
  logic [DATA_BITS-1:0] grant_byte_s;
  logic                 grant_req_valid_s;
  logic                 grant_req_last_s;
  logic                 accept_s;
  logic [ID_W-1:0]      winner_s;
  logic                 any_valid_s;
  logic [ID_W-1:0]      next_ptr_s;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte_s[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  assign grant_byte_s      = req_byte_s[grant_id];
  assign grant_req_valid_s = req_valid[grant_id];
  assign grant_req_last_s  = req_last[grant_id];

  // A byte is handed over only in GRANT, with the grantee valid and the transmitter idle.
  assign accept_s = (state_r == GRANT) && grant_req_valid_s && !tx_busy;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid     (req_valid),
    .ptr       (ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Round-robin pointer after releasing the current grantee: one past it, wrapping.
  always_comb begin
    next_ptr_s = '0;
    if (grant_id == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id + ID_W'(1);
    end
  end

  // Handshake outputs follow the accept condition in the same cycle; tx_data
  // otherwise shows the last byte that was sent.
  always_comb begin
    req_ready = '0;
    tx_send   = accept_s;
    tx_data   = tx_data_r;
    if (accept_s) begin
      req_ready[grant_id] = 1'b1;
      tx_data             = grant_byte_s;
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration FSM: grant, send one byte, wait for the frame, repeat until last or stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr_r       <= '0;
      last_r      <= 1'b0;
      cnt_r       <= '0;
      tx_data_r   <= '0;
      stall_err   <= 1'b0;
    end else begin
      stall_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            grant_id    <= winner_s;
            grant_valid <= 1'b1;
            cnt_r       <= '0;
            state_r     <= GRANT;
          end
        end
        GRANT: begin
          if (accept_s) begin
            tx_data_r <= grant_byte_s;
            last_r    <= grant_req_last_s;
            cnt_r     <= '0;
            state_r   <= WAIT_BUSY;
          end else if (!grant_req_valid_s) begin
            if (cnt_r == STALL_MAX) begin
              stall_err   <= 1'b1;
              grant_valid <= 1'b0;
              ptr_r       <= next_ptr_s;
              cnt_r       <= '0;
              state_r     <= IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        WAIT_BUSY: begin
          // The transmitter raises busy one clock after send; wait for it so a
          // byte is never sent twice.
          if (tx_busy) begin
            state_r <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_r) begin
              grant_valid <= 1'b0;
              ptr_r       <= next_ptr_s;
              state_r     <= IDLE;
            end else begin
              cnt_r   <= '0;
              state_r <= GRANT;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int DB    = 8;
  localparam int STALL = 8;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [1:0] id;
  } send_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_send;
  logic [DB-1:0]    tx_data;
  logic             tx_busy;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             stall_err;

  logic model_busy;
  logic ext_busy;
  int   bcnt;
  int   cyc = 0;
  int   checks;
  int   errors;

  logic [8:0] q [NR][$];
  logic       pend [NR];
  int         ready_cnt [NR];
  send_t      slog [$];
  int         stall_log [$];
  send_t      mon_e;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .STALL_CYCLES(STALL)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .stall_err   (stall_err)
  );

  assign tx_busy = model_busy | ext_busy;

  // Cycle counter used to time-stamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the clock after send and lasts one frame.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (!model_busy && tx_send) begin
      model_busy <= 1'b1;
      bcnt       <= FRAME - 1;
    end else if (model_busy) begin
      if (bcnt == 0) model_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor first, then requester drivers: each requester presents its queue head.
  always @(negedge clk) begin
    if (!rst && tx_send) begin
      mon_e.cyc  = cyc;
      mon_e.data = tx_data;
      mon_e.id   = grant_id;
      slog.push_back(mon_e);
      chk("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
      chk("send_while_busy", 32'(tx_busy), 32'd0);
    end
    if (!rst && stall_err) stall_log.push_back(cyc);
    for (int i = 0; i < NR; i++) begin
      if (!rst && req_ready[i]) ready_cnt[i]++;
      if (pend[i] && q[i].size() > 0) void'(q[i].pop_front());
      pend[i] = !rst && req_ready[i];
      if (q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DB +: DB]  = q[i][0][7:0];
        req_last[i]           = q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    q[r].push_back({last, d});
  endtask

  task automatic clear_env();
    for (int i = 0; i < NR; i++) begin
      q[i].delete();
      pend[i]      = 1'b0;
      ready_cnt[i] = 0;
    end
    slog.delete();
    stall_log.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ext_busy = 1'b0;
    clear_env();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_done(input string tag, input int nsend, input int budget);
    int n = 0;
    while (!(slog.size() >= nsend && !grant_valid) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(slog.size() >= nsend && !grant_valid), 32'd1);
  endtask

  initial begin
    int bad;
    int drop_cyc;
    checks    = 0;
    errors    = 0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    ext_busy  = 1'b0;
    clear_env();

    // Reset values.
    step();
    step();
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id",    32'(grant_id),    32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_tx_send",     32'(tx_send),     32'd0);
    chk("rst_tx_data",     32'(tx_data),     32'd0);
    chk("rst_stall_err",   32'(stall_err),   32'd0);
    rst = 1'b0;
    step();

    // Single requester, three-byte packet.
    push(0, 1'b0, 8'h55);
    push(0, 1'b0, 8'hA3);
    push(0, 1'b1, 8'h0F);
    wait_done("t1_done", 3, 600);
    chk("t1_n",     32'(slog.size()), 32'd3);
    chk("t1_d0",    32'(slog[0].data), 32'h55);
    chk("t1_d1",    32'(slog[1].data), 32'hA3);
    chk("t1_d2",    32'(slog[2].data), 32'h0F);
    chk("t1_id2",   32'(slog[2].id), 32'd0);
    chk("t1_gap01", 32'(slog[1].cyc - slog[0].cyc), 32'(FRAME + 2));
    chk("t1_gap12", 32'(slog[2].cyc - slog[1].cyc), 32'(FRAME + 2));
    chk("t1_fall",  32'(cyc - slog[2].cyc), 32'(FRAME + 2));
    // Pointer now 1: with 0 and 1 both requesting, 1 wins, then 0.
    push(0, 1'b1, 8'hC0);
    push(1, 1'b1, 8'hC1);
    wait_done("t1p_done", 5, 600);
    chk("t1p_id3", 32'(slog[3].id), 32'd1);
    chk("t1p_d3",  32'(slog[3].data), 32'hC1);
    chk("t1p_id4", 32'(slog[4].id), 32'd0);
    chk("t1p_d4",  32'(slog[4].data), 32'hC0);

    // Packet lock: requesters 0 and 2 with two-byte packets.
    do_reset();
    push(0, 1'b0, 8'h11);
    push(0, 1'b1, 8'h12);
    push(2, 1'b0, 8'h21);
    push(2, 1'b1, 8'h22);
    wait_done("t2_done", 4, 800);
    chk("t2_id0", 32'(slog[0].id), 32'd0);
    chk("t2_d0",  32'(slog[0].data), 32'h11);
    chk("t2_id1", 32'(slog[1].id), 32'd0);
    chk("t2_d1",  32'(slog[1].data), 32'h12);
    chk("t2_id2", 32'(slog[2].id), 32'd2);
    chk("t2_d2",  32'(slog[2].data), 32'h21);
    chk("t2_id3", 32'(slog[3].id), 32'd2);
    chk("t2_d3",  32'(slog[3].data), 32'h22);

    // All requesters busy with one-byte packets: rotation 0,1,2,3,0,1.
    do_reset();
    push(0, 1'b1, 8'hA0);
    push(0, 1'b1, 8'hA4);
    push(1, 1'b1, 8'hA1);
    push(1, 1'b1, 8'hA5);
    push(2, 1'b1, 8'hA2);
    push(3, 1'b1, 8'hA3);
    wait_done("t3_done", 6, 1000);
    chk("t3_id0", 32'(slog[0].id), 32'd0);
    chk("t3_id1", 32'(slog[1].id), 32'd1);
    chk("t3_id2", 32'(slog[2].id), 32'd2);
    chk("t3_id3", 32'(slog[3].id), 32'd3);
    chk("t3_id4", 32'(slog[4].id), 32'd0);
    chk("t3_id5", 32'(slog[5].id), 32'd1);
    chk("t3_d5",  32'(slog[5].data), 32'hA5);
    chk("t3_rdy0", 32'(ready_cnt[0]), 32'd2);
    chk("t3_rdy1", 32'(ready_cnt[1]), 32'd2);
    chk("t3_rdy2", 32'(ready_cnt[2]), 32'd1);
    chk("t3_rdy3", 32'(ready_cnt[3]), 32'd1);

    // Stall: requester 1 sends one byte then goes silent; requester 3 waits.
    do_reset();
    push(1, 1'b0, 8'h5A);
    push(3, 1'b1, 8'h3C);
    wait_done("t4_done", 2, 600);
    chk("t4_id0",     32'(slog[0].id), 32'd1);
    chk("t4_d0",      32'(slog[0].data), 32'h5A);
    chk("t4_nstall",  32'(stall_log.size()), 32'd1);
    chk("t4_stall_t", 32'(stall_log[0] - slog[0].cyc), 32'(FRAME + 2 + STALL));
    chk("t4_id1",     32'(slog[1].id), 32'd3);
    chk("t4_d1",      32'(slog[1].data), 32'h3C);

    // Asynchronous reset while waiting for the frame to finish.
    do_reset();
    push(2, 1'b0, 8'h77);
    push(2, 1'b1, 8'h78);
    bad = 0;
    while (slog.size() < 1 && bad < 100) begin
      step();
      bad++;
    end
    repeat (10) step();
    chk("t5_pre_gv",   32'(grant_valid), 32'd1);
    chk("t5_pre_id",   32'(grant_id), 32'd2);
    chk("t5_pre_data", 32'(tx_data), 32'h77);
    #1;
    rst = 1'b1;
    clear_env();
    #1;
    chk("t5_gv",    32'(grant_valid), 32'd0);
    chk("t5_id",    32'(grant_id), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_send",  32'(tx_send), 32'd0);
    chk("t5_data",  32'(tx_data), 32'd0);
    chk("t5_stall", 32'(stall_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    push(1, 1'b1, 8'h99);
    wait_done("t5_done", 1, 300);
    chk("t5_new_id", 32'(slog[0].id), 32'd1);
    chk("t5_new_d",  32'(slog[0].data), 32'h99);

    // Transmitter held busy externally while the grant is held.
    do_reset();
    ext_busy = 1'b1;
    push(0, 1'b1, 8'h42);
    bad = 0;
    repeat (8) begin
      step();
      if (tx_send || req_ready != '0) bad++;
    end
    chk("t6_gv",   32'(grant_valid), 32'd1);
    chk("t6_id",   32'(grant_id), 32'd0);
    chk("t6_hold", 32'(bad), 32'd0);
    chk("t6_none", 32'(slog.size()), 32'd0);
    ext_busy = 1'b0;
    drop_cyc = cyc;
    wait_done("t6_done", 1, 300);
    chk("t6_d",     32'(slog[0].data), 32'h42);
    chk("t6_after", 32'(slog[0].cyc >= drop_cyc), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
